// File: rtl/ula_arbitro_pkg.sv
// ----------------------------------------------------------------------------
// ula_arbitro_pkg
// Shared definitions for the ULA arbiter/sequencer:
//   - ULA opcode constants (OP_SOMA, OP_NEG, OP_SUB, OP_SLT)
//   - FSM state encoding (IDLE, EXEC, RESP)
//   - requester count (N_REQ)
// No ports (package).
// ----------------------------------------------------------------------------
package ula_arbitro_pkg;

    localparam logic [1:0] OP_SOMA = 2'b00;  // add
    localparam logic [1:0] OP_NEG  = 2'b01;  // negate Entrada1
    localparam logic [1:0] OP_SUB  = 2'b10;  // subtract
    localparam logic [1:0] OP_SLT  = 2'b11;  // sign of difference

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ula_arbitro_if.sv
// ----------------------------------------------------------------------------
// ula_arbitro_if
// Bundles every bus signal around the ULA arbiter: requester side
// (req_*), ULA side (ula_*), response side (rsp_*) and busy.
// Modports:
//   slave  - the arbiter (ula_arbitro)
//   master - the environment: requesters, response consumer and the ULA
// Parameter WIDTH: operand/result width.
// ----------------------------------------------------------------------------
interface ula_arbitro_if
    import ula_arbitro_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;

    logic [WIDTH-1:0] ula_entrada1;
    logic [WIDTH-1:0] ula_entrada2;
    logic [1:0]       ula_op;
    logic [WIDTH-1:0] ula_resultado;
    logic             ula_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_resultado;
    logic             rsp_zero;

    logic             busy;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output req_ready,
        output ula_entrada1, ula_entrada2, ula_op,
        input  ula_resultado, ula_zero,
        output rsp_valid, rsp_id, rsp_resultado, rsp_zero,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  req_ready,
        input  ula_entrada1, ula_entrada2, ula_op,
        output ula_resultado, ula_zero,
        input  rsp_valid, rsp_id, rsp_resultado, rsp_zero,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/ula_arb_rr.sv
// ----------------------------------------------------------------------------
// ula_arb_rr
// Two-way grant generator for the ULA arbiter.
//   Default build: round-robin with a last-grant pointer (reset to 1 so that
//   requester 0 wins the first tie). The pointer moves only on acceptance.
//   ULA_ARB_PRIO_FIXA_EN defined: fixed priority, requester 0 wins ties and
//   no pointer register exists.
// Ports:
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   i_req_valid        : per-requester valid
//   i_accept           : a grant was taken this cycle (moves the pointer)
//   o_grant            : one-hot grant, only for a valid requester
//   o_grant_id         : index of the winning requester
// ----------------------------------------------------------------------------
module ula_arb_rr
    import ula_arbitro_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic             i_accept,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_grant_id
);

    logic w_win_id;

`ifdef ULA_ARB_PRIO_FIXA_EN
    // Clock, reset and accept are not needed without a pointer.
    logic w_unused;
    assign w_unused = &{1'b0, i_clock, i_reset_n, i_accept};

    assign w_win_id = ~i_req_valid[0] & i_req_valid[1];
`else
    logic r_last;

    always_comb begin
        w_win_id = 1'b0;
        if (i_req_valid == 2'b11) begin
            // Tie: the requester that did not win last time goes next.
            w_win_id = ~r_last;
        end else if (i_req_valid[1]) begin
            w_win_id = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= w_win_id;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign o_grant[gi] = i_req_valid[gi] && (w_win_id == 1'(gi));
        end
    endgenerate

    assign o_grant_id = w_win_id;

endmodule

// File: rtl/ula_arbitro.sv
// ----------------------------------------------------------------------------
// ula_arbitro
// Shares one combinational ULA between two requesters (0: control/PC path,
// 1: execute stage). One operation in flight at a time:
//   IDLE : grant one valid requester, latch its op/a/b into issue registers
//   EXEC : issue registers drive the ULA; result and Zero captured at the end
//   RESP : response held until rsp_ready; no new request is accepted
// Arbitration mode selected by ULA_ARB_PRIO_FIXA_EN (see ula_arb_rr).
// Ports:
//   i_clock   : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : ula_arbitro_if.slave (requests, ULA lines, response, busy)
// Parameter WIDTH: operand/result width, must match the interface.
// ----------------------------------------------------------------------------
module ula_arbitro
    import ula_arbitro_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    ula_arbitro_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_zero;

    logic [N_REQ-1:0] w_grant;
    logic             w_grant_id;
    logic [N_REQ-1:0] w_ready;
    logic             w_accept;

    ula_arb_rr u_arb (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_req_valid (bus.req_valid),
        .i_accept    (w_accept),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready  = w_grant;
                w_accept = |w_grant;
                if (|w_grant) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Issue and response registers. The issue registers keep driving the ULA
    // in every state, so its inputs never glitch between operations.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_op       <= OP_SOMA;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_rsp_res  <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id <= w_grant_id;
                r_op <= w_grant_id ? bus.req_op1 : bus.req_op0;
                r_a  <= w_grant_id ? bus.req_a1  : bus.req_a0;
                r_b  <= w_grant_id ? bus.req_b1  : bus.req_b0;
            end
            if (r_state == EXEC) begin
                r_rsp_res  <= bus.ula_resultado;
                r_rsp_zero <= bus.ula_zero;
            end
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.ula_entrada1  = r_a;
    assign bus.ula_entrada2  = r_b;
    assign bus.ula_op        = r_op;
    assign bus.rsp_valid     = (r_state == RESP);
    assign bus.rsp_id        = r_id;
    assign bus.rsp_resultado = r_rsp_res;
    assign bus.rsp_zero      = r_rsp_zero;
    assign bus.busy          = (r_state != IDLE);

endmodule
